// File: rtl/index_multibank_buffer_if.sv
// rtl/index_multibank_buffer_if.sv - producer/consumer bus of the multibank index buffer
//
// Groups the write stream, the two read ports, the release pulse and the
// occupancy status of index_multibank_buffer.
//   wr_valid/wr_ready/wr_data/wr_last : producer beat handshake
//   rd_bank_valid/rd_len              : drain bank status
//   rd_en*/rd_addr*/rd_data*/rd_valid*: two random-access read ports
//   rd_done                           : consumer releases the drain bank
//   full_banks/fill_bank/drain_bank   : bank rotation status
// Modport slave is the buffer; modport master is the producer/consumer side.
interface index_multibank_buffer_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 15,
  parameter int NUM_BANKS  = 2
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int FW = $clog2(NUM_BANKS + 1);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  rd_bank_valid;
  logic [ADDR_WIDTH:0]   rd_len;
  logic                  rd_en0;
  logic                  rd_en1;
  logic [ADDR_WIDTH-1:0] rd_addr0;
  logic [ADDR_WIDTH-1:0] rd_addr1;
  logic [DATA_WIDTH-1:0] rd_data0;
  logic [DATA_WIDTH-1:0] rd_data1;
  logic                  rd_valid0;
  logic                  rd_valid1;
  logic                  rd_done;
  logic [FW-1:0]         full_banks;
  logic [BW-1:0]         fill_bank;
  logic [BW-1:0]         drain_bank;

  modport slave (
    input  wr_valid, wr_data, wr_last,
    input  rd_en0, rd_en1, rd_addr0, rd_addr1, rd_done,
    output wr_ready, rd_bank_valid, rd_len,
    output rd_data0, rd_data1, rd_valid0, rd_valid1,
    output full_banks, fill_bank, drain_bank
  );

  modport master (
    output wr_valid, wr_data, wr_last,
    output rd_en0, rd_en1, rd_addr0, rd_addr1, rd_done,
    input  wr_ready, rd_bank_valid, rd_len,
    input  rd_data0, rd_data1, rd_valid0, rd_valid1,
    input  full_banks, fill_bank, drain_bank
  );
endinterface

// File: rtl/index_multibank_buffer.sv
// rtl/index_multibank_buffer.sv - round-robin multibank buffer for sparse column indices
//
// The producer streams one index per beat into the fill bank; a block ends on
// wr_last or when the bank is full. Committed banks are drained in order by the
// consumer through two pipelined read ports and released with rd_done.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : index_multibank_buffer_if.slave (write stream, read ports, status)
module index_multibank_buffer #(
  parameter int K            = 1024,
  parameter int DATA_WIDTH   = $clog2(K),
  parameter int DEPTH        = K * K / 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int NUM_BANKS    = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  index_multibank_buffer_if.slave bus
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int FW = $clog2(NUM_BANKS + 1);
  localparam int LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  bank_state_e           state_q [NUM_BANKS];
  bank_state_e           state_d [NUM_BANKS];
  logic [LW-1:0]         len_q   [NUM_BANKS];
  logic [LW-1:0]         len_d   [NUM_BANKS];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]         fill_q, fill_d;
  logic [BW-1:0]         drain_q, drain_d;
  logic [FW-1:0]         full_q, full_d;
  logic                  wr_ready_q, wr_ready_d;

  logic                  accept;
  logic                  commit;
  logic                  rel;
  logic                  rd_bank_valid;
  logic [LW-1:0]         rd_len;

  logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];

  // Read pipelines, one per port; stage 0 captures the memory word.
  logic [1:0]              rd_en_s;
  logic [ADDR_WIDTH-1:0]   rd_addr_s [2];
  logic [READ_LATENCY-1:0] vld_q     [2];
  logic [DATA_WIDTH-1:0]   dat_q     [2][READ_LATENCY];

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(NUM_BANKS - 1)) ? '0 : b + BW'(1);
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= BANK_EMPTY;
        len_q[b]   <= '0;
      end
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      drain_q    <= '0;
      full_q     <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      drain_q    <= drain_d;
      full_q     <= full_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Next-state logic. The fill bank is never FULL while wr_ready is high, so a
  // commit and a release in the same cycle always touch different banks.
  always_comb begin
    accept     = bus.wr_valid & wr_ready_q;
    commit     = accept & (bus.wr_last | (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)));
    rel        = bus.rd_done & rd_bank_valid;
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    drain_d    = drain_q;
    if (accept) begin
      state_d[fill_q] = commit ? BANK_FULL : BANK_FILLING;
      wr_ptr_d        = commit ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (commit) begin
      len_d[fill_q] = {1'b0, wr_ptr_q} + LW'(1);
      fill_d        = next_bank(fill_q);
    end
    if (rel) begin
      state_d[drain_q] = BANK_EMPTY;
      drain_d          = next_bank(drain_q);
    end
    full_d     = full_q + FW'(commit) - FW'(rel);
    // Registered so that wr_ready never depends on wr_valid.
    wr_ready_d = (state_d[fill_d] != BANK_FULL);
  end

  // Output logic
  always_comb begin
    rd_bank_valid = (state_q[drain_q] == BANK_FULL);
    rd_len        = rd_bank_valid ? len_q[drain_q] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[fill_q][wr_ptr_q] <= bus.wr_data;
    end
  end

  always_comb begin
    rd_en_s      = {bus.rd_en1, bus.rd_en0};
    rd_addr_s[0] = bus.rd_addr0;
    rd_addr_s[1] = bus.rd_addr1;
  end

  // The word is captured when the request is sampled, so a release or a
  // refill of the bank cannot disturb reads already in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p] <= '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
          dat_q[p][i] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p][0] <= rd_en_s[p] & rd_bank_valid;
        dat_q[p][0] <= (rd_en_s[p] && rd_bank_valid && ({1'b0, rd_addr_s[p]} < rd_len))
                       ? mem_q[drain_q][rd_addr_s[p]] : '0;
        for (int i = 1; i < READ_LATENCY; i++) begin
          vld_q[p][i] <= vld_q[p][i-1];
          dat_q[p][i] <= dat_q[p][i-1];
        end
      end
    end
  end

  assign bus.wr_ready      = wr_ready_q;
  assign bus.rd_bank_valid = rd_bank_valid;
  assign bus.rd_len        = rd_len;
  assign bus.rd_valid0     = vld_q[0][READ_LATENCY-1];
  assign bus.rd_valid1     = vld_q[1][READ_LATENCY-1];
  assign bus.rd_data0      = dat_q[0][READ_LATENCY-1];
  assign bus.rd_data1      = dat_q[1][READ_LATENCY-1];
  assign bus.full_banks    = full_q;
  assign bus.fill_bank     = fill_q;
  assign bus.drain_bank    = drain_q;
endmodule

// File: tb/tb_index_multibank_buffer.sv
// tb/tb_index_multibank_buffer.sv - scoreboard bench for index_multibank_buffer
module tb_index_multibank_buffer;
  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int NB    = 2;
  localparam int RL    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  index_multibank_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) bus ();

  index_multibank_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(NB), .READ_LATENCY(RL)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected word whenever a port presents rd_valid.
  always @(negedge clk) begin
    if (bus.rd_valid0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rd0_unexpected actual=valid data=%0d required=no_valid cyc=%0d", bus.rd_data0, cyc);
      end else begin
        e0 = q0.pop_front();
        if (bus.rd_data0 !== e0.data || cyc != e0.due) begin
          errors++;
          $display("FAIL rd0_data actual=%0d@%0d required=%0d@%0d", bus.rd_data0, cyc, e0.data, e0.due);
        end
      end
    end
    if (bus.rd_valid1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rd1_unexpected actual=valid data=%0d required=no_valid cyc=%0d", bus.rd_data1, cyc);
      end else begin
        e1 = q1.pop_front();
        if (bus.rd_data1 !== e1.data || cyc != e1.due) begin
          errors++;
          $display("FAIL rd1_data actual=%0d@%0d required=%0d@%0d", bus.rd_data1, cyc, e1.data, e1.due);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wbeat(input logic [DW-1:0] d, input logic last);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic push(input int port, input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + RL;
    if (port == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  // One-cycle read on a single port; exp_valid=0 means no response is expected.
  task automatic rd(input int port, input int addr, input logic [DW-1:0] d, input logic exp_valid);
    if (port == 0) begin
      bus.rd_en0 = 1'b1; bus.rd_addr0 = AW'(addr);
    end else begin
      bus.rd_en1 = 1'b1; bus.rd_addr1 = AW'(addr);
    end
    if (exp_valid) push(port, d);
    tick();
    bus.rd_en0 = 1'b0;
    bus.rd_en1 = 1'b0;
  endtask

  task automatic done_pulse;
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
    bus.rd_en0 = 1'b0; bus.rd_en1 = 1'b0; bus.rd_addr0 = '0; bus.rd_addr1 = '0;
    bus.rd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_ready", bus.wr_ready, 0);
    chk("reset_rd_bank_valid", bus.rd_bank_valid, 0);
    chk("reset_full_banks", bus.full_banks, 0);
    chk("reset_fill_bank", bus.fill_bank, 0);
    chk("reset_drain_bank", bus.drain_bank, 0);
    chk("reset_rd_len", bus.rd_len, 0);
    chk("reset_rd_valid0", bus.rd_valid0, 0);
    chk("reset_rd_data0", bus.rd_data0, 0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_wr_ready", bus.wr_ready, 1);

    // Reads and release with no committed bank are ignored.
    rd(0, 0, '0, 1'b0);
    done_pulse();
    chk("idle_done_drain", bus.drain_bank, 0);
    chk("idle_done_full", bus.full_banks, 0);

    // Block of three with wr_last.
    wbeat(10'd3, 1'b0); wbeat(10'd5, 1'b0); wbeat(10'd7, 1'b1);
    chk("b3_rd_bank_valid", bus.rd_bank_valid, 1);
    chk("b3_rd_len", bus.rd_len, 3);
    chk("b3_full_banks", bus.full_banks, 1);
    chk("b3_fill_bank", bus.fill_bank, 1);
    rd(0, 1, 10'd5, 1'b1);
    rd(1, 7, 10'd0, 1'b1);
    rd(0, 2, 10'd7, 1'b1);
    done_pulse();
    chk("b3_rel_full", bus.full_banks, 0);
    chk("b3_rel_drain", bus.drain_bank, 1);
    chk("b3_rel_valid", bus.rd_bank_valid, 0);
    chk("b3_rel_len", bus.rd_len, 0);

    // Eight beats without wr_last auto-commit bank1.
    for (int i = 0; i < 8; i++) wbeat(DW'(i), 1'b0);
    chk("auto_rd_len", bus.rd_len, 8);
    chk("auto_fill_bank", bus.fill_bank, 0);
    chk("auto_full_banks", bus.full_banks, 1);
    chk("auto_wr_ready", bus.wr_ready, 1);
    rd(1, 7, 10'd7, 1'b1);
    bus.rd_en0 = 1'b1; bus.rd_addr0 = 3'd4;
    bus.rd_en1 = 1'b1; bus.rd_addr1 = 3'd4;
    push(0, 10'd4); push(1, 10'd4);
    tick();
    bus.rd_en0 = 1'b0; bus.rd_en1 = 1'b0;
    done_pulse();
    chk("auto_rel_drain", bus.drain_bank, 0);

    // Both banks committed: producer stalls.
    wbeat(10'd9, 1'b0); wbeat(10'd1, 1'b1);
    wbeat(10'd20, 1'b0); wbeat(10'd21, 1'b0); wbeat(10'd22, 1'b0); wbeat(10'd23, 1'b1);
    chk("both_wr_ready", bus.wr_ready, 0);
    chk("both_full_banks", bus.full_banks, 2);
    chk("both_rd_len", bus.rd_len, 2);

    // Read sampled together with rd_done returns the released bank's data.
    bus.rd_done = 1'b1;
    rd(0, 0, 10'd9, 1'b1);
    bus.rd_done = 1'b0;
    chk("rel_wr_ready", bus.wr_ready, 1);
    chk("rel_drain_bank", bus.drain_bank, 1);
    chk("rel_rd_len", bus.rd_len, 4);
    chk("rel_full_banks", bus.full_banks, 1);
    rd(0, 2, 10'd22, 1'b1);
    for (int a = 0; a < 4; a++) rd(0, a, DW'(20 + a), 1'b1);
    done_pulse();
    chk("rel2_drain", bus.drain_bank, 0);
    chk("rel2_fill", bus.fill_bank, 0);

    // Commit bank1 in the same cycle bank0 is released.
    wbeat(10'd30, 1'b0); wbeat(10'd31, 1'b1);
    chk("cr_pre_full", bus.full_banks, 1);
    wbeat(10'd40, 1'b0); wbeat(10'd41, 1'b0);
    bus.rd_done = 1'b1;
    wbeat(10'd42, 1'b1);
    bus.rd_done = 1'b0;
    chk("cr_full_banks", bus.full_banks, 1);
    chk("cr_drain_bank", bus.drain_bank, 1);
    chk("cr_fill_bank", bus.fill_bank, 0);
    chk("cr_rd_len", bus.rd_len, 3);
    rd(1, 1, 10'd41, 1'b1);
    repeat (3) tick();

    // Reset mid-block with a read in flight.
    wbeat(10'd60, 1'b0); wbeat(10'd61, 1'b0);
    rd(0, 0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_inflight_valid", bus.rd_valid0, 0);
    repeat (2) tick();
    chk("rst_hold_wr_ready", bus.wr_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_rd_bank_valid", bus.rd_bank_valid, 0);
    chk("rst_full_banks", bus.full_banks, 0);
    chk("rst_fill_bank", bus.fill_bank, 0);
    chk("rst_drain_bank", bus.drain_bank, 0);

    // Fresh block after reset starts at address 0.
    wbeat(10'd50, 1'b0); wbeat(10'd51, 1'b1);
    chk("post_rst_len", bus.rd_len, 2);
    rd(0, 0, 10'd50, 1'b1);
    rd(1, 1, 10'd51, 1'b1);

    for (int w = 0; w < 20 && (q0.size() != 0 || q1.size() != 0); w++) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
